// File: rtl/alu8_sched_pkg.sv
// Shared types for the alu8 scheduler: FSM states and ALU opcode groups.
// Opcode bits [3:1] select the group; bit [0] is the per-group modifier.
package alu8_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ADD   = 3'b000;
  localparam logic [2:0] SUB   = 3'b001;
  localparam logic [2:0] LOGIC = 3'b010;
  localparam logic [2:0] SHIFT = 3'b011;

endpackage

// File: rtl/alu8.sv
// 8-bit combinational ALU; zero latency, no handshake.
// Groups above SHIFT return zero by design rather than flagging an error.
module alu8
  import alu8_sched_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    case (op[3:1])
      ADD:     y = a + b + {7'b0, op[0]};
      SUB:     y = a - b - {7'b0, op[0]};
      LOGIC:   y = op[0] ? (a | b) : (a & b);
      SHIFT:   y = op[0] ? (a >> 1) : (a << 1);
      default: y = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu8_sched.sv
// Round-robin share of one alu8 among NREQ requesters; accept at T gives rsp_valid at T+2.
// A stalled rsp_ready holds RESP with stable outputs and no accepts; a new grant may ride the handshake cycle.
module alu8_sched
  import alu8_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_opcode,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_data,
  output logic                busy
);

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, pick, id_q, rsp_id_q;
  logic [3:0]     op_q;
  logic [7:0]     a_q, b_q, alu_y, rsp_data_q;
  logic           any_valid, accept_en, accept;

  // First valid requester after last_grant, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && v[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign any_valid = |req_valid;
  assign pick      = rr_pick(req_valid, last_grant);
  assign accept_en = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = accept_en && any_valid && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rsp_id has its own register so it stays stable while id_q takes the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      if (accept) begin
        last_grant <= pick;
        id_q       <= pick;
        op_q       <= req_opcode[4*pick +: 4];
        a_q        <= req_a[8*pick +: 8];
        b_q        <= req_b[8*pick +: 8];
      end
      if (state == EXEC) begin
        rsp_data_q <= alu_y;
        rsp_id_q   <= id_q;
      end
    end
  end

  alu8 u_alu8 (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu8_sched.sv
// Directed bench for alu8_sched: latency, opcode sweep, stall, reset mid-op, round-robin order.
module tb_alu8_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_opcode;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
  int          n_run  = 0;
  int          n_fail = 0;

  logic [3:0] sw_op  [7] = '{4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
  logic [7:0] sw_exp [7] = '{8'h11,   8'h0D,   8'h01,   8'h0F,   8'h1E,   8'h07,   8'h00};

  alu8_sched #(.NREQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    req_opcode[4*idx +: 4] = op;
    req_a[8*idx +: 8]      = a;
    req_b[8*idx +: 8]      = b;
  endtask

  // Waits (bounded) for req_ready[idx], then checks the grant vector is exactly that one-hot.
  task automatic wait_ready(input int idx, input string tag);
    int n = 0;
    while (!req_ready[idx] && n < 20) begin
      step();
      n++;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'd1 << idx);
  endtask

  task automatic do_op(input int idx, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input string tag);
    load(idx, op, a, b);
    req_valid[idx] = 1'b1;
    #1;
    wait_ready(idx, tag);
    step();
    req_valid[idx] = 1'b0;
    check({tag, "_t1_valid"}, 32'(rsp_valid), 32'd0);
    step();
    check({tag, "_t2_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(exp));
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    int last_cyc;
    rst        = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    #3;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    do_op(2, 4'b0000, 8'h0F, 8'h01, 8'h10, "single");

    for (int i = 0; i < 7; i++)
      do_op(0, sw_op[i], 8'h0F, 8'h01, sw_exp[i], $sformatf("sweep%0d", i));

    do_op(1, 4'b0001, 8'hFF, 8'h01, 8'h01, "wrap_add");
    do_op(1, 4'b0010, 8'h00, 8'h01, 8'hFF, "wrap_sub");

    // Response stall with another requester pending
    load(0, 4'b0000, 8'h05, 8'h03);
    req_valid[0] = 1'b1;
    #1;
    wait_ready(0, "stall");
    step();
    req_valid[0] = 1'b0;
    load(2, 4'b0100, 8'hF0, 8'h3C);
    req_valid[2] = 1'b1;
    #1;
    check("stall_exec_rdy", 32'(req_ready), 32'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'h08);
      check("stall_id", 32'(rsp_id), 32'd0);
      check("stall_rdy", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_hs_grant", 32'(req_ready), 32'b0100);
    step();
    rsp_ready    = 1'b0;
    req_valid[2] = 1'b0;
    check("stall_next_exec", 32'(rsp_valid), 32'd0);
    step();
    check("stall_next_valid", 32'(rsp_valid), 32'd1);
    check("stall_next_id", 32'(rsp_id), 32'd2);
    check("stall_next_data", 32'(rsp_data), 32'h30);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while in EXEC
    load(3, 4'b0000, 8'h01, 8'h01);
    req_valid[3] = 1'b1;
    #1;
    wait_ready(3, "rstx");
    step();
    req_valid[3] = 1'b0;
    check("rstx_busy_exec", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstx_rsp_data", 32'(rsp_data), 32'd0);
    check("rstx_rsp_id", 32'(rsp_id), 32'd0);
    check("rstx_req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rstx_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end

    // All requesters valid, consumer always ready
    for (int i = 0; i < 4; i++) load(i, 4'b0000, 8'(i * 16), 8'h01);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    check("rr_first_grant", 32'(req_ready), 32'b0001);
    seen     = 0;
    last_cyc = -1;
    for (int c = 0; c < 40 && seen < 8; c++) begin
      step();
      if (rsp_valid) begin
        check("rr_id", 32'(rsp_id), 32'(seen % 4));
        check("rr_data", 32'(rsp_data), 32'((seen % 4) * 16 + 1));
        if (seen > 0) check("rr_gap", 32'(c - last_cyc), 32'd2);
        last_cyc = c;
        seen++;
      end
    end
    check("rr_count", 32'(seen), 32'd8);
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu8_sched.md
# alu8_sched

Round-robin scheduler that shares one `alu8` datapath instance between NREQ independent requesters. It arbitrates valid/ready requests, captures the winner's operands, and executes one operation on the shared ALU. It then returns a registered, ID-tagged result on a single backpressurable response channel. The block sits between the requester blocks and the 8-bit ALU, which it instantiates.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, $clog2(NREQ): requester-ID width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_opcode`  in  4*NREQ  opcode of requester i at bits [4i+3:4i].
- `req_a`, `req_b`  in  8*NREQ  operands of requester i at bits [8i+7:8i].
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  index of the requester that issued the result.
- `rsp_data`  out  8  ALU result.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is set, grant one requester; its `req_ready` is high that cycle and the request is accepted.
  - On accept: latch opcode, a, b and ID; go to EXEC.
- EXEC:
  - Drive the latched operands into `alu8`.
  - Register the ALU output into `rsp_data`; go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_ready`=1: the response completes. If any `req_valid` is set, accept a new grant in the same cycle and go to EXEC; otherwise go to IDLE.
- Arbitration:
  - Round-robin over requesters. Search starts at `last_grant+1` modulo NREQ.
  - `last_grant` updates only on an accepted request.
  - Reset value of `last_grant` is NREQ-1, so requester 0 has first priority.
- `req_ready` is zero in EXEC, and zero in RESP while `rsp_ready`=0.
- ALU semantics, with opcode[3:1] selecting the function and opcode[0] as modifier:
  - 000: a+b+op0, mod 256, carry discarded.
  - 001: a-b-op0, mod 256, borrow discarded.
  - 010: op0 ? a|b : a&b.
  - 011: op0 ? a>>1 : a<<1, zero fill.
  - 100..111: result 8'h00. This is legal and is not an error.
- Requesters must hold their request until accepted; the block never reads operands of a non-granted requester.
- The result width is 8 bits; no flags are exported.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - state=IDLE, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `req_ready`=0, `last_grant`=NREQ-1.
- Latency: accept at cycle T, `rsp_valid` rises at T+2.
- Best-case throughput is 1 op per 2 cycles (back-to-back accept in the RESP handshake cycle).
- Reset mid-operation: the in-flight op is dropped, no response is produced, and the arbiter pointer is restored to its reset value.
- A requester dropping `req_valid` before accept is legal; it is simply not granted.
- With all NREQ requesters continuously valid, each is served exactly once per NREQ grants.
- A stalled `rsp_ready` holds RESP indefinitely, with no accepts and stable outputs.

## Structure
- Package `alu8_sched_pkg`:
  - FSM state enum (IDLE, EXEC, RESP).
  - Opcode-group constants: ADD=3'b000, SUB=3'b001, LOGIC=3'b010, SHIFT=3'b011.
- The single sub-module is `alu8`, instantiated once and driven from the operand latches.
- Round-robin selection stays inline as a function, not a separate module.

## Test plan
- Single request: requester 2, a=8'h0F, b=8'h01, opcode 4'b0000 -> accept at T, `rsp_valid` at T+2, `rsp_data`=8'h10, `rsp_id`=2.
- Opcode sweep, requester 0, a=8'h0F, b=8'h01 -> the required `rsp_data` for each opcode:
  - 4'b0001: 8'h11.
  - 4'b0011: 8'h0D.
  - 4'b0100: 8'h01.
  - 4'b0101: 8'h0F.
  - 4'b0110: 8'h1E.
  - 4'b0111: 8'h07.
  - 4'b1000: 8'h00.
- All 4 requesters valid continuously, `rsp_ready`=1 -> `rsp_id` sequence 0,1,2,3,0,…, with a new `rsp_valid` every 2 cycles.
- `rsp_ready` held low 5 cycles during RESP -> `rsp_data`/`rsp_id` stable, `req_ready`=0 throughout; the next grant occurs in the handshake cycle.
- `rst` asserted in EXEC -> outputs take their reset values immediately, no response appears, and the next grant goes to requester 0.
- Wrap arithmetic: requester 1 with a=8'hFF, b=8'h01, opcode 4'b0001 -> 8'h01; then a=8'h00, b=8'h01, opcode 4'b0010 -> 8'hFF.
